instr_fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/instr_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - bus encodings, fault codes, FSM states and buffer entry type for the fetch stage
package fetch_pkg;

  localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;
  localparam logic [2:0]  HSIZE_WORD     = 3'b010;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_BUS      = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STALL
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - BUF_DEPTH-entry FIFO of fetched {instr, pc, fault}; clear has priority over push/pop
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int AW        = $clog2(BUF_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !i_clear;
  assign w_pop   = i_pop && !o_empty && !i_clear;
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(BUF_DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // An empty buffer presents a NOP so decode never sees stale data
  always_comb begin
    o_head = r_mem[r_rd_ptr];
    if (o_empty) begin
      o_head.instr = NOP_INSTR;
      o_head.pc    = '0;
      o_head.fault = FAULT_NONE;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC register, pipelined AHB-Lite instruction fetch and decode buffer
// Optional FETCH_PERF_CNT_EN adds fetch_count_out / stall_count_out counters.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] pc_next_in,
  input  logic        misaligned_in,
  input  logic        flush_in,
  output logic [31:0] pc_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  input  logic        hready_in,
  input  logic        hresp_in,
  input  logic [31:0] hrdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic [1:0]  instr_fault_out,
  input  logic        decode_ready_in
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_out,
  output logic [31:0] stall_count_out
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  r_state, w_state_nxt;
  logic [31:0]   r_pc, r_cap_pc;
  logic          r_inflight, r_squash, r_pend, r_fault_sent;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_full, w_empty, w_pop, w_push, w_space, w_issue;
  logic          w_accept, w_done, w_data_push, w_fault_push;
  fetch_entry_t  w_push_entry, w_head;

  // The slot freed by this cycle's pop counts, which sustains one fetch per cycle
  assign w_pop   = !w_empty && decode_ready_in;
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_space = w_occ < (CW+1)'(BUF_DEPTH);

  assign w_issue      = (r_state == ST_ADDR) && w_space && !r_pend && !flush_in;
  assign w_accept     = w_issue && hready_in;
  assign w_done       = r_inflight && hready_in;
  assign w_data_push  = w_done && !r_squash && !flush_in;
  assign w_fault_push = (r_state != ST_IDLE) && r_pend && !r_fault_sent && !r_inflight
                        && (!w_full || w_pop) && !flush_in;
  assign w_push       = w_data_push || w_fault_push;

  always_comb begin
    w_push_entry.instr = hrdata_in;
    w_push_entry.pc    = r_cap_pc;
    w_push_entry.fault = hresp_in ? FAULT_BUS : FAULT_NONE;
    if (w_fault_push) begin
      w_push_entry.instr = NOP_INSTR;
      w_push_entry.pc    = r_pc;
      w_push_entry.fault = FAULT_MISALIGN;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    htrans_out  = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = ST_ADDR;
      ST_ADDR:  if (!flush_in && !w_issue) w_state_nxt = ST_STALL;
      ST_STALL: if (flush_in || (w_space && !r_pend)) w_state_nxt = ST_ADDR;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_VECTOR;
      r_cap_pc     <= '0;
      r_inflight   <= 1'b0;
      r_squash     <= 1'b0;
      r_pend       <= 1'b0;
      r_fault_sent <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_inflight <= 1'b1;
        r_cap_pc   <= r_pc;
      end else if (w_done) begin
        r_inflight <= 1'b0;
      end
      // A beat still outstanding across a redirect is drained but never buffered
      if (flush_in)    r_squash <= r_inflight && !hready_in;
      else if (w_done) r_squash <= 1'b0;
      if (flush_in) begin
        r_pc         <= pc_next_in;
        r_pend       <= 1'b0;
        r_fault_sent <= 1'b0;
      end else if (w_accept) begin
        r_pc   <= pc_next_in;
        r_pend <= misaligned_in;
      end
      if (w_fault_push) r_fault_sent <= 1'b1;
    end
  end

  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_push   (w_push),
    .i_entry  (w_push_entry),
    .i_pop    (w_pop),
    .i_clear  (flush_in),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head)
  );

  assign pc_out          = r_pc;
  assign haddr_out       = r_pc;
  assign hwrite_out      = 1'b0;
  assign hsize_out       = HSIZE_WORD;
  assign instr_valid_out = !w_empty;
  assign instr_out       = w_head.instr;
  assign instr_pc_out    = w_head.pc;
  assign instr_fault_out = w_head.fault;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_data_push) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == ST_STALL) || (w_issue && !hready_in)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_count_out = r_fetch_cnt;
  assign stall_count_out = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized bench for instr_fetch_stage against a transaction-level reference model
`timescale 1ns/1ps
module tb_instr_fetch_stage;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] pc_next_in = '0;
  logic        misaligned_in = 1'b0, flush_in = 1'b0;
  logic        hready_in = 1'b1, hresp_in = 1'b0, decode_ready_in = 1'b0;
  logic [31:0] hrdata_in = '0;
  logic [31:0] pc_out, haddr_out, instr_out, instr_pc_out;
  logic [1:0]  htrans_out, instr_fault_out;
  logic [2:0]  hsize_out;
  logic        hwrite_out, instr_valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_out, stall_count_out;
`endif

  always #5 clk_in = ~clk_in;

  instr_fetch_stage #(.RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pc_next_in(pc_next_in), .misaligned_in(misaligned_in),
    .flush_in(flush_in), .pc_out(pc_out), .haddr_out(haddr_out), .htrans_out(htrans_out),
    .hwrite_out(hwrite_out), .hsize_out(hsize_out), .hready_in(hready_in), .hresp_in(hresp_in),
    .hrdata_in(hrdata_in), .instr_valid_out(instr_valid_out), .instr_out(instr_out),
    .instr_pc_out(instr_pc_out), .instr_fault_out(instr_fault_out), .decode_ready_in(decode_ready_in)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count_out(fetch_count_out), .stall_count_out(stall_count_out)
`endif
  );

  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [1:0] fault; } exp_t;

  exp_t        m_q[$];
  logic [31:0] m_pc, m_addr, prev_addr;
  logic        m_out, m_sq, m_pend, m_sent, prev_hold, g_acc;
  int          cyc;
  int          acc_cyc[$], pop_cyc[$];
  logic [31:0] acc_addr[$], pop_pc[$], pop_instr[$];
  logic [1:0]  pop_fault[$];
  int          n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_addr.delete();
    pop_cyc.delete(); pop_pc.delete(); pop_instr.delete(); pop_fault.delete();
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; flush_in = 1'b0; misaligned_in = 1'b0;
    hready_in = 1'b1; hresp_in = 1'b0; decode_ready_in = 1'b0;
    #2;
    check_eq("rst_pc", pc_out, RV);
    check_eq("rst_haddr", haddr_out, RV);
    check_eq("rst_htrans", htrans_out, 2'b00);
    check_eq("rst_valid", instr_valid_out, 1'b0);
    check_eq("rst_instr", instr_out, NOP);
    check_eq("rst_ipc", instr_pc_out, 32'h0);
    check_eq("rst_fault", instr_fault_out, 2'b00);
    check_eq("hwrite", hwrite_out, 1'b0);
    check_eq("hsize", hsize_out, 3'b010);
    m_q.delete();
    m_pc = RV; m_out = 1'b0; m_sq = 1'b0; m_pend = 1'b0; m_sent = 1'b0; m_addr = '0;
    prev_hold = 1'b0; prev_addr = '0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // One clock: drive at the falling edge, check combinational outputs, advance the model
  task automatic step(input logic hr, input logic he, input logic dr, input logic fl,
                      input logic [31:0] pcn, input logic mis);
    logic pop, acc, done;
    int   sz0;
    exp_t e;
    hready_in = hr; hresp_in = he; decode_ready_in = dr; flush_in = fl;
    pc_next_in = pcn; misaligned_in = mis;
    hrdata_in = m_out ? word_of(m_addr) : 32'h0;
    #1;
    sz0 = m_q.size();
    check_eq("pc", pc_out, m_pc);
    check_eq("valid", instr_valid_out, sz0 != 0);
    if (prev_hold && !fl) begin
      check_eq("hold_htrans", htrans_out, 2'b10);
      check_eq("hold_haddr", haddr_out, prev_addr);
    end
    pop = instr_valid_out && dr;
    if (pop && sz0 != 0) begin
      e = m_q.pop_front();
      check_eq("instr", instr_out, e.instr);
      check_eq("instr_pc", instr_pc_out, e.pc);
      check_eq("instr_fault", instr_fault_out, e.fault);
      pop_cyc.push_back(cyc); pop_pc.push_back(instr_pc_out);
      pop_instr.push_back(instr_out); pop_fault.push_back(instr_fault_out);
    end
    if (htrans_out == 2'b10) begin
      check_eq("fetch_while_fault", m_pend, 1'b0);
      check_eq("space", (sz0 + int'(m_out) - int'(pop)) < DEPTH, 1'b1);
      check_eq("haddr", haddr_out, m_pc);
    end
    acc  = (htrans_out == 2'b10) && hr;
    done = m_out && hr;
    g_acc = acc;
    if (acc) begin acc_cyc.push_back(cyc); acc_addr.push_back(haddr_out); end
    if (done && !m_sq && !fl)
      m_q.push_back('{instr: word_of(m_addr), pc: m_addr, fault: (he ? 2'b01 : 2'b00)});
    if (!fl && m_pend && !m_sent && !m_out && m_q.size() < DEPTH) begin
      m_q.push_back('{instr: NOP, pc: m_pc, fault: 2'b10});
      m_sent = 1'b1;
    end
    if (done) begin m_out = 1'b0; m_sq = 1'b0; end
    if (acc)  begin m_out = 1'b1; m_sq = 1'b0; m_addr = m_pc; end
    if (fl) begin
      m_q.delete();
      if (m_out) m_sq = 1'b1;
      m_pc = pcn; m_pend = 1'b0; m_sent = 1'b0;
    end else if (acc) begin
      m_pc = pcn; m_pend = mis; m_sent = 1'b0;
    end
    prev_hold = (htrans_out == 2'b10) && !hr && !fl;
    prev_addr = haddr_out;
    cyc++;
    @(negedge clk_in);
  endtask

  initial begin
    logic        hr, he, dr, fl, mis, found;
    logic [31:0] pcn;
    int          r;
    cyc = 0;
    @(negedge clk_in);

    // sequential zero-wait flow
    do_reset(); clear_logs();
    repeat (8) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("seq_n", acc_addr.size() >= 3 && pop_pc.size() >= 3, 1'b1);
    if (acc_addr.size() >= 3 && pop_pc.size() >= 3) begin
      check_eq("seq_a0", acc_addr[0], 32'h0);
      check_eq("seq_a1", acc_addr[1], 32'h4);
      check_eq("seq_a2", acc_addr[2], 32'h8);
      check_eq("seq_a_b2b", (acc_cyc[1] - acc_cyc[0] == 1) && (acc_cyc[2] - acc_cyc[1] == 1), 1'b1);
      check_eq("seq_p0", pop_pc[0], 32'h0);
      check_eq("seq_p1", pop_pc[1], 32'h4);
      check_eq("seq_p2", pop_pc[2], 32'h8);
      check_eq("seq_p_b2b", (pop_cyc[1] - pop_cyc[0] == 1) && (pop_cyc[2] - pop_cyc[1] == 1), 1'b1);
    end

    // decode back-pressure fills the buffer and stalls fetch
    do_reset(); clear_logs();
    repeat (5) step(1, 0, 0, 0, m_pc + 32'd4, 0);
    check_eq("bp_accepts", acc_addr.size(), 2);
    check_eq("bp_htrans_idle", htrans_out, 2'b00);
    clear_logs();
    repeat (4) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("bp_drain_n", pop_pc.size() >= 2 && acc_addr.size() >= 1, 1'b1);
    if (pop_pc.size() >= 2 && acc_addr.size() >= 1) begin
      check_eq("bp_pop0", pop_pc[0], 32'h0);
      check_eq("bp_pop1", pop_pc[1], 32'h4);
      check_eq("bp_resume", acc_addr[0], 32'h8);
    end

    // wait states on address 0x10, then flush with 0x14 in flight
    do_reset(); clear_logs();
    repeat (5) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("ws_addr", haddr_out, 32'h10);
    repeat (3) step(0, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("ws_addr_held", haddr_out, 32'h10);
    check_eq("ws_htrans_held", htrans_out, 2'b10);
    check_eq("ws_pc_held", pc_out, 32'h10);
    repeat (2) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("pre_flush_addr", acc_addr.size() > 0 ? acc_addr[$] : 32'hFFFF_FFFF, 32'h14);
    step(0, 0, 1, 1, 32'h200, 0);
    clear_logs();
    repeat (6) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("flush_n", pop_pc.size() >= 1 && acc_addr.size() >= 1, 1'b1);
    if (pop_pc.size() >= 1 && acc_addr.size() >= 1) begin
      check_eq("flush_first_pop", pop_pc[0], 32'h200);
      check_eq("flush_first_fetch", acc_addr[0], 32'h200);
    end

    // bus error on 0x20, then misaligned target 0x102
    do_reset(); clear_logs();
    repeat (14) step(1, m_out && (m_addr == 32'h20), 1, 0, m_pc + 32'd4, 0);
    found = 1'b0;
    foreach (pop_pc[i]) if (pop_pc[i] == 32'h20 && pop_fault[i] == 2'b01) found = 1'b1;
    check_eq("bus_fault_0x20", found, 1'b1);
    step(1, 0, 1, 0, 32'h102, 1);
    check_eq("mis_accept", g_acc, 1'b1);
    clear_logs();
    repeat (10) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("mis_no_fetch", acc_addr.size(), 0);
    found = 1'b0;
    foreach (pop_pc[i]) if (pop_pc[i] == 32'h102 && pop_fault[i] == 2'b10 && pop_instr[i] == NOP) found = 1'b1;
    check_eq("mis_entry", found, 1'b1);
    step(1, 0, 1, 1, 32'h300, 0);
    clear_logs();
    repeat (3) step(1, 0, 1, 0, m_pc + 32'd4, 0);
    check_eq("mis_refetch", acc_addr.size() > 0 ? acc_addr[0] : 32'hFFFF_FFFF, 32'h300);

    // randomized traffic with a redirect near the top of the address space and a mid-run reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      hr  = ($urandom_range(99) < 75);
      dr  = ($urandom_range(99) < 65);
      fl  = ($urandom_range(99) < 3);
      he  = ($urandom_range(99) < 8);
      mis = 1'b0;
      pcn = m_pc + 32'd4;
      r   = $urandom_range(99);
      if (r < 3) pcn = $urandom() & ~32'h3;
      else if (r < 5) begin pcn = ($urandom() & ~32'h3) | 32'h2; mis = 1'b1; end
      if (i == 100) begin fl = 1'b1; pcn = 32'hFFFF_FFF0; mis = 1'b0; end
      if (i == 1500) do_reset();
      step(hr, he, dr, fl, pcn, mis);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
